// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register. It carries an opaque data bundle and
// a control bundle from one pipeline stage to the next. A valid/ready handshake
// is used on both sides. A 2-entry skid buffer (main + skid) lets in_ready be
// decoded purely from registered state. This means backpressure from out_ready
// never ripples combinationally to the upstream stage.
//
// Extras:
//   - flush     : synchronous squash. All held entries become a bubble whose
//                 control bundle is zero, so no stores or writebacks escape.
//   - stall_cnt : saturating count of cycles in which the stage held a valid
//                 entry that downstream refused. Used for performance debug.
//
// Ports:
//   clock      in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   flush      in   1       synchronous squash of all held entries
//   in_valid   in   1       upstream holds a valid entry
//   in_ready   out  1       stage can accept an entry this cycle
//   in_data    in   DATA_W  upstream data bundle
//   in_ctrl    in   CTRL_W  upstream control bundle
//   out_valid  out  1       downstream entry valid
//   out_ready  in   1       downstream accepts this cycle
//   out_data   out  DATA_W  held data bundle (main entry)
//   out_ctrl   out  CTRL_W  held control bundle (main entry)
//   stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy of the two storage slots. The main slot fills first.
    // The skid slot only fills when main is blocked.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [CNT_W-1:0]    r_stall_cnt;

    // Datapath load strobes produced by the next-state logic.
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid_in;
    logic                w_stall;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath steering.
    // in_ready is decoded from r_state, so "in_valid" in each state
    // already implies an accepted transfer whenever the state is not FULL.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;

        if (flush) begin
            // A flush squashes everything, including a concurrent input.
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_state_nxt    = ST_BUSY;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_valid && out_ready) begin
                        // Pass-through: the old main leaves and the new entry replaces it.
                        w_load_main_in = 1'b1;
                    end else if (in_valid) begin
                        // Downstream is blocked, so the new entry parks in the skid slot.
                        w_state_nxt    = ST_FULL;
                        w_load_skid_in = 1'b1;
                    end else if (out_ready) begin
                        w_state_nxt    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        w_state_nxt      = ST_BUSY;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage slots.
    // Flush zeroes only the control bundles, so a squashed slot cannot
    // write a register or memory. The data bundles are left untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid_in) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: counts refused cycles and sticks at all-ones.
    // Flush does not touch it, so stall history survives a pipeline squash.
    // ------------------------------------------------------------------
    assign w_stall = (r_state != ST_EMPTY) && !out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all are taken straight from registers or decoded from r_state.
    // ------------------------------------------------------------------
    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_FULL);
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg, using DATA_W=160, CTRL_W=12 and
// CNT_W=4.
//
// The reference model treats the stage as a 2-deep FIFO with the following
// behaviour:
//   - It accepts an entry while it holds fewer than 2 entries.
//   - It presents its head entry while non-empty.
//   - It empties on flush or reset.
// Accepted entries are pushed to a scoreboard. A separate monitor pops the
// scoreboard on every output transfer and compares the result.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam int CW = 12;
    localparam int NW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t mq[$];   // model occupancy: entries currently held by the stage
    ent_t sb[$];   // scoreboard: accepted entries awaiting emission
    ent_t held;    // what out_data/out_ctrl should show
    int   m_stall;
    bit   started;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: runs at the negedge, away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            chk("out_valid", DW'(out_valid), DW'(mq.size() > 0));
            chk("in_ready",  DW'(in_ready),  DW'(mq.size() < 2));
            chk("out_data",  out_data, held.d);
            chk("out_ctrl",  DW'(out_ctrl), DW'(held.c));
            chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
            if (!reset && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got out transfer expected none");
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("sb_data", out_data, e.d);
                    chk("sb_ctrl", DW'(out_ctrl), DW'(e.c));
                end
            end
        end
    end

    // The model advances using the inputs that the coming posedge will sample.
    task automatic model_update();
        bit   ov;
        bit   ir;
        ent_t e;
        ov = (mq.size() > 0);
        ir = (mq.size() < 2);
        e.d = in_data;
        e.c = in_ctrl;
        if (reset) begin
            mq.delete();
            sb.delete();
            held    = '0;
            m_stall = 0;
            started = 1'b1;
        end else begin
            if (ov && !out_ready && m_stall < (1 << NW) - 1) m_stall++;
            if (flush) begin
                mq.delete();
                sb.delete();
                held.c = '0;
            end else begin
                if (ov && out_ready) void'(mq.pop_front());
                if (in_valid && ir) begin
                    mq.push_back(e);
                    sb.push_back(e);
                end
                if (mq.size() > 0) held = mq[0];
            end
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // One clock cycle: drive the inputs, update the model, then cross the edge.
    task automatic step(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input bit ordy, input bit fl, input bit rst);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clock);
        #1;
        model_update();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0] aa;
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        held    = '0;
        m_stall = 0;
        for (int i = 0; i < DW / 8; i++) aa[i*8 +: 8] = 8'hAA;
        @(posedge clock);
        #1;

        // 1: single entry after reset
        step(0, '0, '0, 0, 0, 1);
        step(1, aa, 12'hFFF, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // 2: stream 1..8 at full throughput
        for (int i = 1; i <= 8; i++) step(1, DW'(i), CW'(i), 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // 3: A then B with backpressure, then release
        step(1, DW'(160'hA), CW'(12'h00A), 0, 0, 0);
        step(1, DW'(160'hB), CW'(12'h00B), 0, 0, 0);
        step(1, DW'(160'hE), CW'(12'h00E), 0, 0, 0);  // refused: stage full
        step(0, '0, '0, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // 4: flush while full, with a concurrent input C
        step(1, DW'(160'hA1), CW'(12'h0A1), 0, 0, 0);
        step(1, DW'(160'hB1), CW'(12'h0B1), 0, 0, 0);
        step(1, DW'(160'hC1), CW'(12'h0C1), 0, 1, 0);
        step(0, '0, '0, 1, 0, 0);
        step(1, DW'(160'hD1), CW'(12'h0D1), 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // 5: counter saturation, then reset
        step(1, rnd_data(), CW'($urandom()), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, '0, '0, 0, 0, 0);
        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 0, 0);

        // 6: reset, flush and input in the same cycle
        step(1, rnd_data(), CW'($urandom()), 0, 0, 0);
        step(1, rnd_data(), CW'($urandom()), 0, 0, 0);
        step(1, rnd_data(), CW'($urandom()), 1, 1, 1);
        step(0, '0, '0, 1, 0, 0);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd_data(), CW'($urandom()),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 99) == 0);
        end

        // drain and confirm nothing was lost
        for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0, 0);
        chk("sb_drained", DW'(sb.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the next generation of the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data bundle and a control bundle between stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure does not need a combinational ready path.
- Adds synchronous flush (bubble insertion) and a saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 160, width of data bundle (e.g. IR, PC, Result, Branch, Jump = 5x32)
CTRL_W, 12, width of control bundle (RegWrite, MemRead, MemWrite, MemToReg, Branch, Jump, Zero, RegDest[4:0])
CNT_W, 16, width of stall counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream holds a valid entry
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  held data bundle (main entry)
out_ctrl  out  CTRL_W  held control bundle (main entry)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Transfer rules:
  - Input transfer occurs on an edge where in_valid and in_ready are both 1.
  - Output transfer occurs on an edge where out_valid and out_ready are both 1.
- Storage: main entry (drives out_*) and skid entry, each holding data, ctrl and valid.
- States:
  - EMPTY: no valid entries.
  - BUSY: main valid, skid empty.
  - FULL: both valid.
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), decoded from registered state only. There is no combinational path from out_ready or in_valid to in_ready.
- Transitions (no flush, no reset):
  - EMPTY: in_valid -> BUSY, main <= in. Otherwise stay.
  - BUSY, in_valid and out_ready -> BUSY, main <= in.
  - BUSY, in_valid and !out_ready -> FULL, skid <= in.
  - BUSY, !in_valid and out_ready -> EMPTY.
  - BUSY, neither -> hold.
  - FULL, out_ready -> BUSY, main <= skid. Input is ignored because in_ready=0.
  - FULL, !out_ready -> hold.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Latency: an entry accepted at edge N into EMPTY is visible on out_* after edge N, for the cycle N+1. Full throughput is one entry per cycle while out_ready=1.
- Flush, sampled at an edge and taking priority over all handshakes:
  - state <= EMPTY.
  - main and skid ctrl <= 0, so the bubble carries RegWrite=MemWrite=0.
  - Data registers hold their values.
  - A concurrent input is discarded.
  - stall_cnt is unaffected.
- Reset (priority over flush):
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_data=0, out_ctrl=0, skid cleared.
  - stall_cnt=0.
  - Reset asserted mid-transfer discards all held entries.
- stall_cnt increments at each edge where out_valid=1 and out_ready=0 (pre-edge values). It holds at 2^CNT_W-1 and does not wrap.
- While out_valid=0, out_data and out_ctrl hold their last values. Downstream must qualify them with out_valid.
- Outputs are registered; there is no combinational path from any input to any output.

Test Plan:
1. Reset, then drive in_valid=1, in_data=AAAA..AA, in_ctrl=12'hFFF with out_ready=1 -> out_valid=1 and out_data=AAAA..AA on the next cycle; in_ready stays 1.
2. Stream 8 entries with values 1..8 and out_ready=1 every cycle -> outputs 1..8 on consecutive cycles, no gaps; stall_cnt=0.
3. Load entries A then B with out_ready=0 -> state FULL, in_ready=0, out_data=A, stall_cnt counts 1,2,...; raise out_ready -> A then B emitted in order, in_ready returns to 1 one cycle after A leaves.
4. FULL with A and B, assert flush for one cycle with in_valid=1 and value C -> next cycle out_valid=0, out_ctrl=0, C is not emitted; the next accepted entry D emits normally.
5. Hold out_ready=0 with out_valid=1 and CNT_W=4 for 20 cycles -> stall_cnt saturates at 15; reset -> stall_cnt=0 and out_data=0.
6. Assert reset in the same cycle as flush and in_valid -> all outputs equal their reset values and in_ready=1 on the next cycle.
